exc_pc_redirect: RTL and testbench
==================================

EXC_PC_REDIRECT -- requirements
Module: exc_pc_redirect

Interface
REQ-001 SHALL have parameter EXC_HANDLER, default 32'h0000_4180, exception handler entry PC.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port m_pc  input  32  PC of the instruction currently in the M stage.
REQ-005 SHALL have port m_valid  input  1  M stage holds a real (non-bubble) instruction.
REQ-006 SHALL have port m_bd  input  1  M instruction sits in a branch delay slot.
REQ-007 SHALL have port exc_req  input  1  exception raised by the M instruction.
REQ-008 SHALL have port exc_code  input  5  ExcCode of the raised exception.
REQ-009 SHALL have port eret_req  input  1  M instruction is ERET.
REQ-010 SHALL have port fetch_ready  input  1  fetch stage accepts redirect this cycle.
REQ-011 SHALL have port redirect_valid  output  1  redirect request to fetch.
REQ-012 SHALL have port redirect_pc  output  32  target PC of the redirect.
REQ-013 SHALL have port flush  output  1  flush F/D/E/M pipeline registers.
REQ-014 SHALL have port epc  output  32  saved exception PC.
REQ-015 SHALL have port exl  output  1  exception level bit.
REQ-016 SHALL have port cause_code  output  5  latched ExcCode.
REQ-017 SHALL have port cause_bd  output  1  latched branch-delay flag.

Function
REQ-018 SHALL implement three states: RUN, EXC_RDR, ERET_RDR; all outputs registered except flush.
REQ-019 In RUN, exc_req && m_valid && !exl SHALL capture epc, cause_code<=exc_code, cause_bd, set exl=1, redirect_pc<=EXC_HANDLER, redirect_valid<=1, go EXC_RDR.
REQ-020 In RUN, eret_req && m_valid && exl && !exc_req SHALL set redirect_pc<=epc, redirect_valid<=1, go ERET_RDR.
REQ-021 exc_req and eret_req in the same cycle: exception SHALL win; ERET discarded.
REQ-022 exc_req while exl=1, eret_req while exl=0, or either with m_valid=0 SHALL be ignored (no state/output change).
REQ-023 Latency: qualifying request sampled at edge N SHALL give redirect_valid=1 from cycle N+1.
REQ-024 redirect_valid and redirect_pc SHALL stay stable until the cycle with fetch_ready=1; on that edge redirect_valid<=0 and state<=RUN.
REQ-025 In ERET_RDR, the handshake edge SHALL also clear exl.
REQ-026 While in EXC_RDR/ERET_RDR, all new exc_req/eret_req SHALL be ignored.
REQ-027 flush SHALL equal redirect_valid combinationally.
REQ-028 epc arithmetic SHALL be 32-bit modulo 2^32; m_pc low bits passed unchanged (no alignment check).
REQ-029 fetch_ready asserted while redirect_valid=0 SHALL have no effect.

Reset
REQ-030 reset SHALL force state=RUN, redirect_valid=0, redirect_pc=0, epc=0, exl=0, cause_code=0, cause_bd=0 on the next edge, including mid-redirect; reset overrides all requests.

Configuration
REQ-031 Macro EPC_BD_ADJUST_EN defined: on exception capture, m_bd=1 SHALL give epc=m_pc-4 and cause_bd=1; m_bd=0 gives epc=m_pc, cause_bd=0.
REQ-032 Macro EPC_BD_ADJUST_EN undefined: epc=m_pc always, cause_bd SHALL remain 0, m_bd ignored.

Verification
REQ-033 m_pc=0x0000_3010, m_valid=1, exc_req=1, exc_code=5'd4, fetch_ready=1 -> next cycle redirect_valid=1, flush=1, redirect_pc=0x0000_4180, epc=0x0000_3010, exl=1, cause_code=4; following cycle redirect_valid=0.
REQ-034 Exception with fetch_ready=0 for 3 cycles then 1 -> redirect_valid/redirect_pc held 3+ cycles, dropped one edge after fetch_ready=1; exc_req pulse during hold ignored (epc unchanged).
REQ-035 With EPC_BD_ADJUST_EN: m_pc=0x0000_0000, m_bd=1, exc_req=1 -> epc=0xFFFF_FFFC, cause_bd=1; without macro -> epc=0x0000_0000, cause_bd=0.
REQ-036 exl=1, epc=0x0000_3010, eret_req=1, exc_req=0 -> redirect_pc=0x0000_3010; exl cleared on handshake edge; eret_req with exl=0 -> no redirect.
REQ-037 exc_req=1 and eret_req=1 together -> exception redirect to 0x0000_4180; exc_req with m_valid=0 -> no response.
REQ-038 reset asserted while in EXC_RDR with redirect_valid=1 -> next cycle all outputs 0, state RUN, subsequent exception accepted normally.

Source files
------------

// File: rtl/exc_pc_redirect.sv
// Exception / ERET PC redirect controller for the M stage.
// Optional macro EPC_BD_ADJUST_EN: back EPC up to the branch when the faulting op is in a delay slot.
module exc_pc_redirect #(
  parameter logic [31:0] EXC_HANDLER = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_pc,
  input  logic        m_valid,
  input  logic        m_bd,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        eret_req,
  input  logic        fetch_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] epc,
  output logic        exl,
  output logic [4:0]  cause_code,
  output logic        cause_bd
);

  typedef enum logic [1:0] {StRun, StExcRdr, StEretRdr} state_e;

  state_e      state_q, state_d;
  logic        redirect_valid_d;
  logic [31:0] redirect_pc_d;
  logic [31:0] epc_d;
  logic        exl_d;
  logic [4:0]  cause_code_d;
  logic        cause_bd_d;
  logic [31:0] epc_capture;
  logic        bd_capture;

`ifdef EPC_BD_ADJUST_EN
  assign epc_capture = m_bd ? (m_pc - 32'd4) : m_pc;
  assign bd_capture  = m_bd;
`else
  logic unused_m_bd;
  assign unused_m_bd = m_bd;
  assign epc_capture = m_pc;
  assign bd_capture  = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid;
    redirect_pc_d    = redirect_pc;
    epc_d            = epc;
    exl_d            = exl;
    cause_code_d     = cause_code;
    cause_bd_d       = cause_bd;
    unique case (state_q)
      StRun: begin
        // Exception has priority; a simultaneous ERET is dropped.
        if (m_valid && exc_req && !exl) begin
          epc_d            = epc_capture;
          cause_code_d     = exc_code;
          cause_bd_d       = bd_capture;
          exl_d            = 1'b1;
          redirect_pc_d    = EXC_HANDLER;
          redirect_valid_d = 1'b1;
          state_d          = StExcRdr;
        end else if (m_valid && eret_req && exl && !exc_req) begin
          redirect_pc_d    = epc;
          redirect_valid_d = 1'b1;
          state_d          = StEretRdr;
        end
      end
      StExcRdr: begin
        if (fetch_ready) begin
          redirect_valid_d = 1'b0;
          state_d          = StRun;
        end
      end
      StEretRdr: begin
        if (fetch_ready) begin
          redirect_valid_d = 1'b0;
          exl_d            = 1'b0;
          state_d          = StRun;
        end
      end
      default: begin
        redirect_valid_d = 1'b0;
        state_d          = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      epc            <= 32'd0;
      exl            <= 1'b0;
      cause_code     <= 5'd0;
      cause_bd       <= 1'b0;
    end else begin
      state_q        <= state_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      epc            <= epc_d;
      exl            <= exl_d;
      cause_code     <= cause_code_d;
      cause_bd       <= cause_bd_d;
    end
  end

  assign flush = redirect_valid;

endmodule

// File: tb/tb_exc_pc_redirect.sv
// Directed and randomized bench for exc_pc_redirect against a behavioural model.
module tb_exc_pc_redirect;

  localparam logic [31:0] Handler = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, m_valid, m_bd, exc_req, eret_req, fetch_ready;
  logic [31:0] m_pc;
  logic [4:0]  exc_code;
  logic        redirect_valid, flush, exl, cause_bd;
  logic [31:0] redirect_pc, epc;
  logic [4:0]  cause_code;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a pending redirect plus the architectural CP0 bits.
  bit          md_pending;
  bit          md_is_eret;
  logic [31:0] md_target, md_epc;
  bit          md_exl, md_bd;
  logic [4:0]  md_code;

  exc_pc_redirect #(.EXC_HANDLER(Handler)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_pc          (m_pc),
    .m_valid       (m_valid),
    .m_bd          (m_bd),
    .exc_req       (exc_req),
    .exc_code      (exc_code),
    .eret_req      (eret_req),
    .fetch_ready   (fetch_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .epc           (epc),
    .exl           (exl),
    .cause_code    (cause_code),
    .cause_bd      (cause_bd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply what the spec says happens at a clock edge, given the sampled inputs.
  task automatic model_edge();
    if (reset) begin
      md_pending = 0; md_is_eret = 0; md_target = '0; md_epc = '0;
      md_exl = 0; md_code = '0; md_bd = 0;
    end else if (md_pending) begin
      if (fetch_ready) begin
        md_pending = 0;
        if (md_is_eret) md_exl = 0;
      end
    end else if (m_valid && exc_req && !md_exl) begin
`ifdef EPC_BD_ADJUST_EN
      md_epc = m_bd ? m_pc + 32'hFFFF_FFFC : m_pc;
      md_bd  = m_bd;
`else
      md_epc = m_pc;
      md_bd  = 0;
`endif
      md_code = exc_code; md_exl = 1; md_target = Handler;
      md_pending = 1; md_is_eret = 0;
    end else if (m_valid && eret_req && !exc_req && md_exl) begin
      md_target = md_epc; md_pending = 1; md_is_eret = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rv"},    {31'd0, redirect_valid}, {31'd0, md_pending});
    chk({tag, ".flush"}, {31'd0, flush},          {31'd0, md_pending});
    chk({tag, ".rpc"},   redirect_pc,             md_target);
    chk({tag, ".epc"},   epc,                     md_epc);
    chk({tag, ".exl"},   {31'd0, exl},            {31'd0, md_exl});
    chk({tag, ".code"},  {27'd0, cause_code},     {27'd0, md_code});
    chk({tag, ".bd"},    {31'd0, cause_bd},       {31'd0, md_bd});
  endtask

  task automatic step(input string tag, input logic rst, input logic v, input logic bd,
                      input logic exc, input logic eret, input logic fr,
                      input logic [31:0] pc, input logic [4:0] code);
    reset = rst; m_valid = v; m_bd = bd; exc_req = exc; eret_req = eret;
    fetch_ready = fr; m_pc = pc; exc_code = code;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    md_pending = 0; md_is_eret = 0; md_target = '0; md_epc = '0;
    md_exl = 0; md_code = '0; md_bd = 0;

    step("reset",   1, 0, 0, 0, 0, 0, 32'h0, 5'd0);
    step("reset2",  1, 1, 1, 1, 1, 1, 32'h1234, 5'd7);

    // Basic exception with fetch already ready.
    step("exc_basic", 0, 1, 0, 1, 0, 1, 32'h0000_3010, 5'd4);
    chk("exc_basic.rpc_const", redirect_pc, 32'h0000_4180);
    chk("exc_basic.epc_const", epc, 32'h0000_3010);
    step("exc_drop", 0, 0, 0, 0, 0, 1, 32'h0, 5'd0);
    chk("exc_drop.rv_const", {31'd0, redirect_valid}, 32'd0);

    // ERET back to saved EPC, exl cleared on the handshake.
    step("eret_req",  0, 1, 0, 0, 1, 0, 32'h0000_4200, 5'd0);
    chk("eret.rpc_const", redirect_pc, 32'h0000_3010);
    step("eret_hold", 0, 1, 0, 0, 1, 0, 32'h0000_4200, 5'd0);
    step("eret_hs",   0, 0, 0, 0, 0, 1, 32'h0, 5'd0);
    chk("eret_hs.exl_const", {31'd0, exl}, 32'd0);
    step("eret_noexl", 0, 1, 0, 0, 1, 1, 32'h0000_4204, 5'd0);

    // Held redirect under backpressure; a second exception is ignored.
    step("hold0", 0, 1, 0, 1, 0, 0, 32'h0000_5000, 5'd12);
    step("hold1", 0, 0, 0, 0, 0, 0, 32'h0, 5'd0);
    step("hold2", 0, 1, 0, 1, 0, 0, 32'h0000_6000, 5'd10);
    chk("hold2.epc_const", epc, 32'h0000_5000);
    step("hold3", 0, 0, 0, 0, 0, 0, 32'h0, 5'd0);
    step("hold_hs", 0, 0, 0, 0, 0, 1, 32'h0, 5'd0);
    step("exl_blocks", 0, 1, 0, 1, 0, 1, 32'h0000_7777, 5'd3);

    // Simultaneous exception and ERET: exception wins.
    step("rst_a", 1, 0, 0, 0, 0, 0, 32'h0, 5'd0);
    step("both",  0, 1, 0, 1, 1, 1, 32'h0000_7000, 5'd8);
    chk("both.rpc_const", redirect_pc, 32'h0000_4180);
    step("rst_b", 1, 0, 0, 0, 0, 0, 32'h0, 5'd0);
    step("bubble", 0, 0, 0, 1, 0, 1, 32'h0000_7100, 5'd8);

    // Delay-slot exception at PC 0: EPC wraps when adjustment is enabled.
    step("bd_wrap", 0, 1, 1, 1, 0, 0, 32'h0000_0000, 5'd6);
`ifdef EPC_BD_ADJUST_EN
    chk("bd_wrap.epc_const", epc, 32'hFFFF_FFFC);
    chk("bd_wrap.bd_const", {31'd0, cause_bd}, 32'd1);
`else
    chk("bd_wrap.epc_const", epc, 32'h0000_0000);
    chk("bd_wrap.bd_const", {31'd0, cause_bd}, 32'd0);
`endif

    // Reset in the middle of a pending redirect, then a fresh exception.
    step("mid_rst", 1, 1, 0, 1, 0, 0, 32'h0000_1111, 5'd2);
    step("post_rst", 0, 1, 0, 1, 0, 1, 32'h0000_8000, 5'd9);
    step("post_hs",  0, 0, 0, 0, 0, 1, 32'h0, 5'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           1'($urandom),
           $urandom,
           5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
